// File: rtl/aes_block_packer.sv
// aes_block_packer
//   Word-serial front end for an AES-128 core. Gathers a 128-bit key and a
//   128-bit plaintext from a WORD_W-bit valid/ready stream, holds
//   encrypt_enable until the core reports round 10, captures the ciphertext
//   and replays it as a WORD_W-bit valid/ready stream, MS word first.
//
//   clk, n_rst            clock (rising edge), async active-low reset
//   flush                 synchronous abort back to LOAD with all state cleared
//   in_word/valid/ready   input stream: key words, then plaintext words
//   key_out, data_out     assembled key / plaintext to the core
//   encrypt_enable        start/hold request to the core
//   core_count            core round counter
//   core_result           core ciphertext, valid when core_count == 10
//   out_word/valid/ready  output ciphertext stream
//   done                  1-cycle pulse after the last ciphertext word is taken
//   timeout_err           1-cycle pulse when the core took too long

module aes_block_packer #(
    parameter int unsigned WORD_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              flush,
    input  logic [WORD_W-1:0] in_word,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [127:0]      key_out,
    output logic [127:0]      data_out,
    output logic              encrypt_enable,
    input  logic [3:0]        core_count,
    input  logic [127:0]      core_result,
    output logic [WORD_W-1:0] out_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done,
    output logic              timeout_err
);

    localparam int unsigned NW   = 128 / WORD_W;
    localparam int unsigned WC_W = $clog2(2 * NW) + 1;
    localparam int unsigned OC_W = $clog2(NW) + 1;
    localparam int unsigned TC_W = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {LOAD, ENCRYPT, UNLOAD} state_e;

    state_e            state_q, state_d;
    logic [WC_W-1:0]   wc_q, wc_d;
    logic [OC_W-1:0]   oc_q, oc_d;
    logic [TC_W-1:0]   tc_q, tc_d;
    logic              armed_q, armed_d;
    logic [127:0]      key_q, key_d;
    logic [127:0]      data_q, data_d;
    logic [127:0]      result_q, result_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              capture;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= LOAD;
            wc_q      <= '0;
            oc_q      <= '0;
            tc_q      <= '0;
            armed_q   <= 1'b0;
            key_q     <= '0;
            data_q    <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wc_q      <= wc_d;
            oc_q      <= oc_d;
            tc_q      <= tc_d;
            armed_q   <= armed_d;
            key_q     <= key_d;
            data_q    <= data_d;
            result_q  <= result_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    // armed_q only reflects earlier ENCRYPT cycles, so a round count already
    // sitting at 10 on entry (left over from the previous block) is ignored.
    assign capture = (state_q == ENCRYPT) && armed_q && (core_count == 4'd10);

    always_comb begin
        state_d   = state_q;
        wc_d      = wc_q;
        oc_d      = oc_q;
        tc_d      = tc_q;
        armed_d   = armed_q;
        key_d     = key_q;
        data_d    = data_q;
        result_d  = result_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;

        unique case (state_q)
            LOAD: begin
                if (in_valid) begin
                    // Shift-in form is also valid when WORD_W == 128.
                    if (wc_q < WC_W'(NW)) key_d  = (key_q << WORD_W) | 128'(in_word);
                    else                  data_d = (data_q << WORD_W) | 128'(in_word);
                    if (wc_q == WC_W'(2 * NW - 1)) begin
                        wc_d    = '0;
                        tc_d    = '0;
                        armed_d = 1'b0;
                        state_d = ENCRYPT;
                    end else begin
                        wc_d = wc_q + 1'b1;
                    end
                end
            end
            ENCRYPT: begin
                armed_d = armed_q | (core_count != 4'd10);
                if (capture) begin
                    result_d = core_result;
                    tc_d     = '0;
                    state_d  = UNLOAD;
                end else if (tc_q == TC_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    key_d     = '0;
                    data_d    = '0;
                    tc_d      = '0;
                    state_d   = LOAD;
                end else begin
                    tc_d = tc_q + 1'b1;
                end
            end
            UNLOAD: begin
                if (out_ready) begin
                    result_d = result_q << WORD_W;
                    if (oc_q == OC_W'(NW - 1)) begin
                        oc_d     = '0;
                        result_d = '0;
                        done_d   = 1'b1;
                        state_d  = LOAD;
                    end else begin
                        oc_d = oc_q + 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase

        if (flush) begin
            state_d   = LOAD;
            wc_d      = '0;
            oc_d      = '0;
            tc_d      = '0;
            armed_d   = 1'b0;
            key_d     = '0;
            data_d    = '0;
            result_d  = '0;
            done_d    = 1'b0;
            timeout_d = 1'b0;
        end
    end

    assign in_ready       = (state_q == LOAD);
    assign encrypt_enable = (state_q == ENCRYPT);
    assign out_valid      = (state_q == UNLOAD);
    assign out_word       = result_q[127 -: WORD_W];
    assign key_out        = key_q;
    assign data_out       = data_q;
    assign done           = done_q;
    assign timeout_err    = timeout_q;

endmodule

// File: tb/tb_aes_block_packer.sv
module tb_aes_block_packer;

    localparam int W  = 32;
    localparam int NW = 4;
    localparam int T  = 64;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          flush = 1'b0;
    logic [W-1:0]  in_word = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [127:0]  key_out, data_out;
    logic          encrypt_enable;
    logic [3:0]    core_count;
    logic [127:0]  core_result = '0;
    logic [W-1:0]  out_word;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          done, timeout_err;

    int checks = 0;
    int errors = 0;
    int mode   = 0;
    int en_cyc = 0;

    aes_block_packer #(.WORD_W(W), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .n_rst(n_rst), .flush(flush),
        .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
        .key_out(key_out), .data_out(data_out), .encrypt_enable(encrypt_enable),
        .core_count(core_count), .core_result(core_result),
        .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
        .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Core environment: round count as a function of cycles since encrypt_enable rose.
    // mode 0: stale 10 on the entry cycle, then 0..10 and hold
    // mode 1: stuck at 3
    // mode 2: 10 for three cycles, then 0..10 and hold
    function automatic logic [3:0] seq(input int m, input int idx);
        int v;
        case (m)
            0:       v = (idx == 0) ? 10 : idx - 1;
            1:       v = 3;
            default: v = (idx < 3) ? 10 : idx - 3;
        endcase
        if (v > 10) v = 10;
        return 4'(v);
    endfunction

    always @(posedge clk) en_cyc <= encrypt_enable ? en_cyc + 1 : 0;
    always_comb core_count = encrypt_enable ? seq(mode, en_cyc) : 4'd10;

    // First ENCRYPT cycle index at which a capture happens, or -1 for timeout.
    function automatic int capture_idx(input int m);
        bit seen = 0;
        for (int i = 0; i < T; i++) begin
            if (seen && seq(m, i) == 4'd10) return i;
            if (seq(m, i) != 4'd10) seen = 1;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    typedef struct {
        string        name;
        logic [127:0] key, pt, res;
        logic [31:0]  w[4];
        int           mode, in_gap, out_stall, fl_at;
    } vec_t;

    function automatic vec_t mk(input string n, input logic [127:0] k, p, r,
                                input logic [31:0] w0, w1, w2, w3,
                                input int m, ig, os, fa);
        vec_t v;
        v.name = n; v.key = k; v.pt = p; v.res = r;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
        v.mode = m; v.in_gap = ig; v.out_stall = os; v.fl_at = fa;
        return v;
    endfunction

    task automatic run_block(input vec_t v);
        logic [31:0] words[8];
        int          i, budget, cyc, exp_k, got, stall_cnt;
        bit          bad_ee, bad_hold, bad_done, prev_stall, tog;
        logic [31:0] prev_word;

        for (int j = 0; j < 4; j++) begin
            words[j]     = v.key[127 - 32*j -: 32];
            words[j + 4] = v.pt[127 - 32*j -: 32];
        end
        mode = v.mode;
        core_result = v.res;

        i = 0; budget = 0; bad_ee = 0; tog = 1;
        while (i < 8 && budget < 1000) begin
            @(negedge clk);
            if (encrypt_enable) bad_ee = 1;
            case (v.in_gap)
                0:       in_valid = 1'b1;
                1:       begin in_valid = tog; tog = !tog; end
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_word = in_valid ? words[i] : 32'hdead_beef;
            if (in_valid && in_ready) i++;
            budget++;
        end
        if (i < 8) begin chk({v.name, ".load_budget"}, i, 8); in_valid = 0; return; end
        @(negedge clk);
        in_valid = 1'b0;
        chk({v.name, ".ee_low_during_load"}, bad_ee, 0);
        chk({v.name, ".ee_one_cycle_after"}, encrypt_enable, 1);
        chk({v.name, ".in_ready_low"}, in_ready, 0);
        chk({v.name, ".key_out"}, key_out, v.key);
        chk({v.name, ".data_out"}, data_out, v.pt);

        exp_k = capture_idx(v.mode);
        cyc = 0; bad_hold = 0;
        while (!out_valid && !timeout_err && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (encrypt_enable && (key_out !== v.key || data_out !== v.pt)) bad_hold = 1;
        end
        chk({v.name, ".key_data_held"}, bad_hold, 0);
        if (exp_k < 0) begin
            chk({v.name, ".timeout_cycle"}, cyc, T);
            chk({v.name, ".timeout_err"}, timeout_err, 1);
            chk({v.name, ".timeout_in_ready"}, in_ready, 1);
            chk({v.name, ".timeout_key_zero"}, key_out, 0);
            chk({v.name, ".timeout_data_zero"}, data_out, 0);
            @(negedge clk);
            chk({v.name, ".timeout_pulse_end"}, timeout_err, 0);
            return;
        end
        chk({v.name, ".capture_latency"}, cyc, exp_k + 1);
        chk({v.name, ".out_valid"}, out_valid, 1);
        chk({v.name, ".ee_dropped"}, encrypt_enable, 0);

        got = 0; budget = 0; stall_cnt = 0; prev_stall = 0; bad_done = 0; prev_word = '0;
        while (got < NW && budget < 500) begin
            if (prev_stall) begin
                chk({v.name, ".hold_valid"}, out_valid, 1);
                chk({v.name, ".hold_word"}, out_word, prev_word);
            end
            if (done) bad_done = 1;
            if (v.fl_at >= 0 && got == v.fl_at) begin
                flush = 1'b1; out_ready = 1'b0;
                @(negedge clk);
                flush = 1'b0;
                chk({v.name, ".flush_out_valid"}, out_valid, 0);
                chk({v.name, ".flush_in_ready"}, in_ready, 1);
                chk({v.name, ".flush_out_word"}, out_word, 0);
                bad_done = 0;
                repeat (3) begin
                    if (done) bad_done = 1;
                    @(negedge clk);
                end
                chk({v.name, ".flush_no_done"}, bad_done, 0);
                return;
            end
            case (v.out_stall)
                0: out_ready = 1'b1;
                1: if (got == 1 && stall_cnt < 5) begin out_ready = 1'b0; stall_cnt++; end
                   else out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_valid && out_ready) begin
                chk($sformatf("%s.word%0d", v.name, got), out_word, v.w[got]);
                got++;
                prev_stall = 0;
            end else begin
                prev_stall = out_valid;
            end
            prev_word = out_word;
            budget++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        if (got < NW) begin chk({v.name, ".unload_budget"}, got, NW); return; end
        chk({v.name, ".no_early_done"}, bad_done, 0);
        chk({v.name, ".done_pulse"}, done, 1);
        chk({v.name, ".out_valid_low"}, out_valid, 0);
        chk({v.name, ".in_ready_back"}, in_ready, 1);
        @(negedge clk);
        chk({v.name, ".done_one_cycle"}, done, 0);
    endtask

    initial begin
        vec_t         tbl[5];
        vec_t         rv;
        logic [127:0] k, p, r;
        int           acc;

        #2ms;
        $display("FAIL global_time_limit act=running exp=finished");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t         tbl[5];
        vec_t         rv;
        logic [127:0] k, p, r;
        int           acc;

        tbl[0] = mk("fips_c1", 128'h000102030405060708090a0b0c0d0e0f,
                    128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                    32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a, 0, 0, 0, -1);
        tbl[1] = mk("gap_stall", 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3243f6a8885a308d313198a2e0370734,
                    128'h3925841d02dc09fbdc118597196a0b32,
                    32'h3925841d, 32'h02dc09fb, 32'hdc118597, 32'h196a0b32, 2, 1, 1, -1);
        tbl[2] = mk("stuck3", 128'hffffffffffffffffffffffffffffffff,
                    128'h0123456789abcdeffedcba9876543210, 128'h0,
                    32'h0, 32'h0, 32'h0, 32'h0, 1, 0, 0, -1);
        tbl[3] = mk("unload_flush", 128'h11111111222222223333333344444444,
                    128'h55555555666666667777777788888888,
                    128'ha5a5a5a55a5a5a5a0f0f0f0ff0f0f0f0,
                    32'ha5a5a5a5, 32'h5a5a5a5a, 32'h0f0f0f0f, 32'hf0f0f0f0, 0, 0, 0, 2);
        tbl[4] = mk("rand_hs", 128'hcafef00ddeadbeef0badc0de12345678,
                    128'h87654321fedcba980011223344556677,
                    128'h80000000000000010000000000000001,
                    32'h80000000, 32'h00000001, 32'h00000000, 32'h00000001, 0, 2, 2, -1);

        #12;
        chk("rst.in_ready", in_ready, 1);
        chk("rst.ee", encrypt_enable, 0);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.out_word", out_word, 0);
        chk("rst.done", done, 0);
        chk("rst.timeout_err", timeout_err, 0);
        chk("rst.key_out", key_out, 0);
        chk("rst.data_out", data_out, 0);
        @(negedge clk);
        n_rst = 1'b1;

        // Asynchronous reset mid-load discards partial words.
        acc = 0;
        while (acc < 3) begin
            @(negedge clk);
            in_valid = 1'b1; in_word = 32'h1234_0000 + 32'(acc);
            if (in_ready) acc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2 n_rst = 1'b0;
        #1;
        chk("async_rst.key_out", key_out, 0);
        chk("async_rst.in_ready", in_ready, 1);
        #2 n_rst = 1'b1;

        for (int t = 0; t < 5; t++) run_block(tbl[t]);

        // Flush after five input words; the following block must load from word 0.
        acc = 0;
        while (acc < 5) begin
            @(negedge clk);
            in_valid = 1'b1; in_word = 32'habcd_0000 + 32'(acc);
            if (in_ready) acc++;
        end
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_load.in_ready", in_ready, 1);
        chk("flush_load.key_out", key_out, 0);
        chk("flush_load.data_out", data_out, 0);
        chk("flush_load.ee", encrypt_enable, 0);
        run_block(tbl[0]);

        for (int n = 0; n < 6; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            r = {$urandom, $urandom, $urandom, $urandom};
            rv = mk($sformatf("rand%0d", n), k, p, r,
                    r[127:96], r[95:64], r[63:32], r[31:0],
                    ($urandom_range(0, 1) == 0) ? 0 : 2,
                    $urandom_range(0, 2), $urandom_range(0, 2), -1);
            run_block(rv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
